// File: rtl/proc_pkg.sv
// Shared write-back definitions: RV32I load funct3 encodings, FSM states and
// the load legality rule used when a load is accepted.
package proc_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_WAIT_LOAD = 1'b1
   } wb_state_e;

   // Known width and naturally aligned; bytes are always aligned.
   function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_LB, F3_LBU: ok = 1'b1;
         F3_LH, F3_LHU: ok = (off[0] == 1'b0);
         F3_LW:         ok = (off == 2'b00);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational byte/half/word extraction from a full read word, followed by
// sign or zero extension according to the load funct3.
module load_align
   import proc_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] value_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (offset_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      value_o = word_i;
      case (funct3_i)
         F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  value_o = {24'h0, byte_sel};
         F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  value_o = {16'h0, half_sel};
         default: value_o = word_i;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: retires ALU results, runs the single outstanding load,
// drives one registered register-file write per instruction, flags load-use.
module writeback_unit
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_data,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   output logic        load_hazard,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        wb_enable,
   output logic        err_misaligned
);

   wb_state_e   state_q;
   logic [4:0]  pend_rd_q;
   logic [2:0]  pend_f3_q;
   logic [1:0]  pend_off_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] wb_data_q;
   logic        wb_en_q;
   logic        err_q;

   logic        accept;
   logic        legal;
   logic [31:0] load_val;

   assign ex_ready      = (state_q == WB_IDLE);
   assign accept        = ex_valid && ex_ready;
   assign legal         = load_legal(ex_funct3, ex_data[1:0]);
   assign mem_req_valid = accept && ex_is_load && legal;
   assign mem_req_addr  = {ex_data[31:2], 2'b00};

   // No hazard once the write is on the port: the register file forwards it.
   assign load_hazard = (state_q == WB_WAIT_LOAD) && (pend_rd_q != 5'd0) &&
                        ((pend_rd_q == dec_rs1) || (pend_rd_q == dec_rs2));

   load_align u_align (
      .word_i   (mem_rsp_data),
      .offset_i (pend_off_q),
      .funct3_i (pend_f3_q),
      .value_o  (load_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WB_IDLE;
         pend_rd_q  <= 5'd0;
         pend_f3_q  <= 3'd0;
         pend_off_q <= 2'd0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_en_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wb_en_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            WB_IDLE: begin
               if (accept) begin
                  if (!ex_is_load) begin
                     wb_addr_q <= ex_rd;
                     wb_data_q <= ex_data;
                     wb_en_q   <= (ex_rd != 5'd0);
                  end else if (legal) begin
                     pend_rd_q  <= ex_rd;
                     pend_f3_q  <= ex_funct3;
                     pend_off_q <= ex_data[1:0];
                     state_q    <= WB_WAIT_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WB_WAIT_LOAD: begin
               if (mem_rsp_valid) begin
                  wb_addr_q <= pend_rd_q;
                  wb_data_q <= load_val;
                  wb_en_q   <= (pend_rd_q != 5'd0);
                  state_q   <= WB_IDLE;
               end
            end
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   assign wb_addr        = wb_addr_q;
   assign wb_data        = wb_data_q;
   assign wb_enable      = wb_en_q;
   assign err_misaligned = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: inputs change 1ns after a rising edge,
// outputs are sampled at that same point (registered) or 1ns after driving.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic        ex_is_load = 1'b0;
   logic [4:0]  ex_rd = 5'd0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [31:0] ex_data = 32'd0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = 32'd0;
   logic [4:0]  dec_rs1 = 5'd0;
   logic [4:0]  dec_rs2 = 5'd0;
   logic        load_hazard;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_enable;
   logic        err_misaligned;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   writeback_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_is_load     (ex_is_load),
      .ex_rd          (ex_rd),
      .ex_funct3      (ex_funct3),
      .ex_data        (ex_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .dec_rs1        (dec_rs1),
      .dec_rs2        (dec_rs2),
      .load_hazard    (load_hazard),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .wb_enable      (wb_enable),
      .err_misaligned (err_misaligned)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic ld, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] d);
      ex_valid = 1'b1; ex_is_load = ld; ex_rd = rd; ex_funct3 = f3; ex_data = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wb_enable, err_misaligned, load_hazard, mem_req_valid} !== 4'b0000 ||
          wb_addr !== 5'd0 || wb_data !== 32'd0 || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: en=%b err=%b hz=%b req=%b addr=%0d data=%h rdy=%b, want all 0 rdy=1",
                  wb_enable, err_misaligned, load_hazard, mem_req_valid, wb_addr, wb_data, ex_ready);
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      drive_ex(1'b0, 5'd5, 3'd0, 32'hDEADBEEF);
      #1;
      checks++;
      if (ex_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL alu_accept: rdy=%b req=%b, want 1 0", ex_ready, mem_req_valid);
      end
      tick();
      ex_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL alu_write: en=%b addr=%0d data=%h, want 1 5 deadbeef", wb_enable, wb_addr, wb_data);
      end
      tick();
      checks++;
      if (wb_enable !== 1'b0) begin
         failures++;
         $display("FAIL alu_pulse: en=%b, want 0", wb_enable);
      end
   endtask

   task automatic test_byte(input logic [2:0] f3, input logic [31:0] exp);
      drive_ex(1'b1, 5'd7, f3, 32'h0000_1003);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000) begin
         failures++;
         $display("FAIL byte_req f3=%0d: req=%b addr=%h, want 1 00001000", f3, mem_req_valid, mem_req_addr);
      end
      tick();
      ex_valid = 1'b0;
      checks++;
      if (ex_ready !== 1'b0 || mem_req_valid !== 1'b0 || wb_enable !== 1'b0) begin
         failures++;
         $display("FAIL byte_wait f3=%0d: rdy=%b req=%b en=%b, want 0 0 0", f3, ex_ready, mem_req_valid, wb_enable);
      end
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h80FF_0000;
      tick();
      mem_rsp_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd7 || wb_data !== exp || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL byte_write f3=%0d: en=%b addr=%0d data=%h rdy=%b, want 1 7 %h 1",
                  f3, wb_enable, wb_addr, wb_data, ex_ready, exp);
      end
      tick();
      checks++;
      if (wb_enable !== 1'b0) begin
         failures++;
         $display("FAIL byte_pulse f3=%0d: en=%b, want 0", f3, wb_enable);
      end
   endtask

   task automatic test_half_hazard();
      drive_ex(1'b1, 5'd3, 3'b001, 32'h0000_2002);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2000) begin
         failures++;
         $display("FAIL lh_req: req=%b addr=%h, want 1 00002000", mem_req_valid, mem_req_addr);
      end
      tick();
      ex_valid = 1'b0;
      dec_rs1 = 5'd1; dec_rs2 = 5'd3;
      #1;
      checks++;
      if (load_hazard !== 1'b1 || ex_ready !== 1'b0) begin
         failures++;
         $display("FAIL lh_hazard: hz=%b rdy=%b, want 1 0", load_hazard, ex_ready);
      end
      dec_rs1 = 5'd4; dec_rs2 = 5'd4;
      #1;
      checks++;
      if (load_hazard !== 1'b0) begin
         failures++;
         $display("FAIL lh_no_hazard: hz=%b, want 0", load_hazard);
      end
      dec_rs1 = 5'd3;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h8001_1234;
      tick();
      mem_rsp_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'hFFFF8001 || load_hazard !== 1'b0) begin
         failures++;
         $display("FAIL lh_write: en=%b addr=%0d data=%h hz=%b, want 1 3 ffff8001 0",
                  wb_enable, wb_addr, wb_data, load_hazard);
      end
      dec_rs1 = 5'd0; dec_rs2 = 5'd0;
      tick();
   endtask

   task automatic test_illegal(input logic [2:0] f3, input logic [31:0] a);
      drive_ex(1'b1, 5'd9, f3, a);
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL illegal_req f3=%0d a=%h: req=%b rdy=%b, want 0 1", f3, a, mem_req_valid, ex_ready);
      end
      tick();
      ex_valid = 1'b0;
      checks++;
      if (err_misaligned !== 1'b1 || wb_enable !== 1'b0 || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL illegal_err f3=%0d: err=%b en=%b rdy=%b, want 1 0 1", f3, err_misaligned, wb_enable, ex_ready);
      end
      tick();
      checks++;
      if (err_misaligned !== 1'b0 || wb_enable !== 1'b0) begin
         failures++;
         $display("FAIL illegal_pulse f3=%0d: err=%b en=%b, want 0 0", f3, err_misaligned, wb_enable);
      end
   endtask

   task automatic test_x0_load();
      drive_ex(1'b1, 5'd0, 3'b010, 32'h0000_3000);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_3000) begin
         failures++;
         $display("FAIL x0_req: req=%b addr=%h, want 1 00003000", mem_req_valid, mem_req_addr);
      end
      tick();
      ex_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
      #1;
      checks++;
      if (load_hazard !== 1'b0 || ex_ready !== 1'b0) begin
         failures++;
         $display("FAIL x0_wait: hz=%b rdy=%b, want 0 0", load_hazard, ex_ready);
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
      tick();
      mem_rsp_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b0 || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL x0_done: en=%b rdy=%b, want 0 1", wb_enable, ex_ready);
      end
   endtask

   // Load retires in M+1 while an ALU op is accepted in the same cycle.
   task automatic test_back_to_back();
      drive_ex(1'b1, 5'd10, 3'b101, 32'h0000_4002);
      tick();
      ex_valid = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_0000;
      tick();
      mem_rsp_valid = 1'b0;
      drive_ex(1'b0, 5'd11, 3'd0, 32'h0000_00AA);
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'h0000BEEF || ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_load: en=%b addr=%0d data=%h rdy=%b, want 1 10 0000beef 1",
                  wb_enable, wb_addr, wb_data, ex_ready);
      end
      tick();
      drive_ex(1'b0, 5'd12, 3'd0, 32'h0000_00BB);
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd11 || wb_data !== 32'h000000AA) begin
         failures++;
         $display("FAIL b2b_alu1: en=%b addr=%0d data=%h, want 1 11 000000aa", wb_enable, wb_addr, wb_data);
      end
      tick();
      ex_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b1 || wb_addr !== 5'd12 || wb_data !== 32'h000000BB) begin
         failures++;
         $display("FAIL b2b_alu2: en=%b addr=%0d data=%h, want 1 12 000000bb", wb_enable, wb_addr, wb_data);
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      drive_ex(1'b1, 5'd7, 3'b000, 32'h0000_5001);
      tick();
      ex_valid = 1'b0; dec_rs1 = 5'd7;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ex_ready !== 1'b1 || load_hazard !== 1'b0 || wb_enable !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid: rdy=%b hz=%b en=%b, want 1 0 0", ex_ready, load_hazard, wb_enable);
      end
      tick();
      rst_n = 1'b1;
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
      tick();
      mem_rsp_valid = 1'b0;
      checks++;
      if (wb_enable !== 1'b0 || ex_ready !== 1'b1 || load_hazard !== 1'b0 || err_misaligned !== 1'b0 ||
          wb_addr !== 5'd0 || wb_data !== 32'd0) begin
         failures++;
         $display("FAIL rst_late_rsp: en=%b rdy=%b hz=%b err=%b addr=%0d data=%h, want 0 1 0 0 0 0",
                  wb_enable, ex_ready, load_hazard, err_misaligned, wb_addr, wb_data);
      end
      dec_rs1 = 5'd0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_byte(3'b000, 32'hFFFF_FF80);
      test_byte(3'b100, 32'h0000_0080);
      test_half_hazard();
      test_illegal(3'b010, 32'h0000_1001);
      test_illegal(3'b001, 32'h0000_1003);
      test_illegal(3'b011, 32'h0000_1000);
      test_x0_load();
      test_back_to_back();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the processor, directly upstream of the register file write port. Takes completed ALU results and load requests from execute. Runs the single outstanding data-memory load, then aligns and sign/zero-extends the response. Drives one registered register-file write per retired instruction and flags load-use hazards to decode.

## Interface
Parameters: none. Fixed 32-bit data, 5-bit register addresses.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  unit accepts instruction this cycle
- ex_is_load  in  1  1 = load; ex_data is byte address; 0 = ex_data is result
- ex_rd  in  5  destination register
- ex_funct3  in  3  load width/sign (RV32I encoding); ignored for non-loads
- ex_data  in  32  ALU result or load address
- mem_req_valid  out  1  load request strobe
- mem_req_addr  out  32  word-aligned address
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  full word read
- dec_rs1, dec_rs2  in  5 each  decode source registers
- load_hazard  out  1  decode must stall
- wb_addr  out  5  to register file dst_addr
- wb_data  out  32  to register file dst_data
- wb_enable  out  1  to register file write_enable
- err_misaligned  out  1  one-cycle pulse on rejected load

## Operation
- FSM states: IDLE, WAIT_LOAD. ex_ready = (state == IDLE), combinational.
- Accept = ex_valid && ex_ready.
- Non-load accept:
  - next cycle wb_addr = ex_rd, wb_data = ex_data.
  - wb_enable = (ex_rd != 0).
  - Stays IDLE.
- Load accept, legal:
  - Legal = funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU} and aligned. Aligned means LH/LHU offset in {0,2}, LW offset 0, bytes any; offset = ex_data[1:0].
  - Same cycle: mem_req_valid = 1, mem_req_addr = {ex_data[31:2], 2'b00}, both combinational.
  - Latch rd, funct3 and offset; go to WAIT_LOAD.
- Load accept, illegal (misaligned or funct3 011/110/111):
  - No request, no write.
  - err_misaligned = 1 the next cycle; stays IDLE.
- WAIT_LOAD with mem_rsp_valid:
  - Extract the byte/half at the latched offset from mem_rsp_data, then sign- or zero-extend per funct3.
  - Next cycle drive wb_* with wb_enable = (rd != 0); return to IDLE.
- Load to x0 still waits for the response but never writes.
- mem_rsp_valid while IDLE is ignored.
- load_hazard = (state == WAIT_LOAD) && pending_rd != 0 && (pending_rd == dec_rs1 || pending_rd == dec_rs2).
- No hazard in the wb_enable cycle: the register file forwards a same-cycle write to its read ports.

## Timing
- Reset (async assert, sync release): state IDLE. wb_addr 0, wb_data 0, wb_enable 0, err_misaligned 0, latched rd/funct3/offset 0.
- Reset mid-load drops the pending load; a later mem_rsp_valid is ignored.
- ALU latency: accepted cycle N, write visible on wb_* in cycle N+1, held exactly one cycle.
- Load latency: response in cycle M, write in cycle M+1. Earliest M is N+1, so a load takes at least 2 cycles.
- ex_ready returns high in cycle M+1. A new instruction accepted in M+1 writes in M+2, so there is never more than one write per cycle.
- wb_enable, err_misaligned: single-cycle pulses.
- mem_req_valid: exactly one cycle per legal load.

## Structure
- Package proc_pkg holds:
  - the funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - the FSM state typedef (WB_IDLE, WB_WAIT_LOAD)
- Sub-module load_align: combinational. Inputs word, offset, funct3; output 32-bit extended value. Reused by future store/MMIO paths.

## Test plan
- ALU op, rd=5, data=0xDEADBEEF accepted cycle 0 -> cycle 1 wb_enable=1, wb_addr=5, wb_data=0xDEADBEEF; cycle 2 wb_enable=0.
- LB, addr 0x1003, rd=7:
  - mem_req_addr=0x1000.
  - Response 0x80FF_0000 two cycles later -> wb_data=0xFFFFFF80, one cycle after the response.
  - The same with LBU -> 0x00000080.
- LH, addr 0x2002, rd=3, response 0x8001_1234 -> wb_data=0xFFFF8001. During WAIT_LOAD, dec_rs2=3 -> load_hazard=1 and ex_ready=0; dec_rs1=dec_rs2=4 -> load_hazard=0.
- LW at 0x1001 -> no mem_req_valid, err_misaligned pulse next cycle, wb_enable stays 0, ex_ready stays 1.
- LW to rd=0 -> request issued and response consumed. wb_enable stays 0 and load_hazard stays 0 with dec_rs1=0.
- rst_n pulled low during WAIT_LOAD, then released; a late mem_rsp_valid arrives -> no write, state IDLE, all outputs 0.
